// File: rtl/pe_grid_unloader_if.sv
// Row-major readback stream from the PE grid unloader: one grid element per
// handshake, tagged with its (row, col) position and an end-of-frame flag.
interface pe_grid_unloader_if #(
  parameter int unsigned Dw  = 16,
  parameter int unsigned RcW = 3
);
  logic [Dw-1:0]  data;
  logic [RcW-1:0] row;
  logic [RcW-1:0] col;
  logic           last;
  logic           valid;
  logic           ready;

  modport master (
    output data,
    output row,
    output col,
    output last,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  row,
    input  col,
    input  last,
    input  valid,
    output ready
  );
endinterface

// File: rtl/pe_grid_unloader.sv
// Counts solver iterations of the PE array, snapshots the N x N solution grid,
// then streams the snapshot out row-major over a valid/ready interface.
module pe_grid_unloader #(
  parameter int unsigned N     = 5,
  parameter int unsigned Dw    = 16,
  parameter int unsigned Iters = 11
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [N*N*Dw-1:0]   uij_flat_i,
  output logic                solver_en_o,
  output logic                busy_o,
  output logic                done_o,
  pe_grid_unloader_if.master  out_if
);

  localparam int unsigned RcW  = $clog2(N);
  localparam int unsigned IdxW = $clog2(N * N);
  localparam int unsigned CntW = 16;

  localparam logic [CntW-1:0] IterLast = CntW'(Iters - 1);
  localparam logic [RcW-1:0]  RcLast   = RcW'(N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIter,
    StSnap,
    StStream,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [RcW-1:0]          row_q, row_d;
  logic [RcW-1:0]          col_q, col_d;
  logic [N*N-1:0][Dw-1:0]  snap_q;

  logic            valid;
  logic            last;
  logic            xfer;
  logic [IdxW-1:0] idx;

  assign valid = (state_q == StStream);
  assign last  = (row_q == RcLast) && (col_q == RcLast);
  assign xfer  = valid && out_if.ready;
  assign idx   = IdxW'(row_q) * IdxW'(N) + IdxW'(col_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StIter;
          cnt_d   = '0;
        end
      end
      StIter: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IterLast) begin
          state_d = StSnap;
        end
      end
      StSnap: begin
        state_d = StStream;
      end
      StStream: begin
        if (xfer) begin
          if (last) begin
            state_d = StDone;
            row_d   = '0;
            col_d   = '0;
          end else if (col_q == RcLast) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDone: begin
        // A start on the done cycle chains straight into the next frame.
        if (start_i) begin
          state_d = StIter;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Snapshot content is only observable while streaming, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (state_q == StSnap) begin
      snap_q <= uij_flat_i;
    end
  end

  always_comb begin
    solver_en_o  = (state_q == StIter);
    busy_o       = (state_q == StIter) || (state_q == StSnap) || (state_q == StStream);
    done_o       = (state_q == StDone);
    out_if.valid = valid;
    out_if.last  = valid && last;
    out_if.row   = row_q;
    out_if.col   = col_q;
    out_if.data  = valid ? snap_q[idx] : '0;
  end

endmodule

// File: tb/tb_pe_grid_unloader.sv
// Directed frames with randomized grids and ready patterns, checked against a
// queue-based model of the expected row-major word sequence.
module tb_pe_grid_unloader;

  localparam int unsigned N     = 5;
  localparam int unsigned Dw    = 16;
  localparam int unsigned Iters = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [N*N*Dw-1:0] uij;
  logic              solver_en;
  logic              busy;
  logic              done;

  int n_tests = 0;
  int n_fail  = 0;

  pe_grid_unloader_if #(.Dw(Dw), .RcW(3)) out_if ();

  pe_grid_unloader #(
    .N     (N),
    .Dw    (Dw),
    .Iters (Iters)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .uij_flat_i  (uij),
    .solver_en_o (solver_en),
    .busy_o      (busy),
    .done_o      (done),
    .out_if      (out_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*N*Dw-1:0] pattern_grid();
    logic [N*N*Dw-1:0] g;
    for (int r = 0; r < int'(N); r++) begin
      for (int c = 0; c < int'(N); c++) begin
        g[(r*N+c)*Dw +: Dw] = Dw'(r * 16 + c);
      end
    end
    return g;
  endfunction

  function automatic logic [N*N*Dw-1:0] rand_grid();
    logic [N*N*Dw-1:0] g;
    for (int k = 0; k < int'(N * N); k++) begin
      g[k*Dw +: Dw] = Dw'($urandom);
    end
    return g;
  endfunction

  // rmode: 0 = always ready, 1 = ready pattern 1,0,0 repeating, 2 = random ready.
  // reset_at: word index at which reset is applied (-1 for none).
  task automatic run_frame(input bit started, input int rmode, input bit corrupt,
                           input bit start_mid, input int reset_at, input bit restart);
    logic [Dw-1:0] exp_q[$];
    int            cyc;
    int            k;
    int            phase;
    logic          rdy;

    if (!started) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end

    cyc = 0;
    while (solver_en === 1'b1 && cyc < 1000) begin
      cyc++;
      tick();
    end
    chk("iter_count", cyc, Iters);
    chk("snap_busy", busy, 1);
    chk("snap_valid", out_if.valid, 0);

    exp_q = {};
    for (int i = 0; i < int'(N * N); i++) begin
      exp_q.push_back(uij[i*Dw +: Dw]);
    end
    tick();
    if (corrupt) begin
      uij = rand_grid();
    end

    k     = 0;
    cyc   = 0;
    phase = 0;
    while (k < int'(N * N) && cyc < 2000) begin
      chk("strm_valid", out_if.valid, 1);
      chk("strm_data", out_if.data, exp_q[k]);
      chk("strm_row", out_if.row, k / N);
      chk("strm_col", out_if.col, k % N);
      chk("strm_last", out_if.last, (k == int'(N * N) - 1));
      chk("strm_busy", busy, 1);
      if (reset_at == k) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_valid", out_if.valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_solver", solver_en, 0);
        tick();
        chk("rst_done2", done, 0);
        chk("rst_busy2", busy, 0);
        return;
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (phase % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      phase++;
      out_if.ready = rdy;
      start = start_mid && (k == 10);
      tick();
      start = 1'b0;
      if (rdy) begin
        k++;
      end
      cyc++;
    end
    chk("stream_bound", k, N * N);
    chk("done_pulse", done, 1);
    chk("done_valid", out_if.valid, 0);
    chk("done_last", out_if.last, 0);
    chk("done_busy", busy, 0);
    out_if.ready = 1'($urandom_range(0, 1));

    if (restart) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_iter", solver_en, 1);
      chk("restart_busy", busy, 1);
      return;
    end
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_if.valid, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b1;
    uij          = pattern_grid();
    out_if.ready = 1'b1;

    repeat (2) begin
      tick();
      chk("rst_solver_en", solver_en, 0);
      chk("rst_out_valid", out_if.valid, 0);
      chk("rst_out_last", out_if.last, 0);
      chk("rst_out_data", out_if.data, 0);
      chk("rst_out_row", out_if.row, 0);
      chk("rst_out_col", out_if.col, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    chk("post_rst_solver_en", solver_en, 0);

    // Counting and a full back-to-back stream of the r*16+c pattern.
    run_frame(1'b0, 0, 1'b0, 1'b0, -1, 1'b0);

    // Backpressure with the input grid changed during streaming.
    uij = pattern_grid();
    run_frame(1'b0, 1, 1'b1, 1'b0, -1, 1'b0);

    // Ignored start mid-stream, then restart on the done cycle.
    uij = rand_grid();
    run_frame(1'b0, 2, 1'b1, 1'b1, -1, 1'b1);
    run_frame(1'b1, 0, 1'b0, 1'b0, -1, 1'b0);

    // Reset at word 7, then a clean frame from (0,0).
    uij = pattern_grid();
    run_frame(1'b0, 2, 1'b0, 1'b0, 7, 1'b0);
    uij = rand_grid();
    run_frame(1'b0, 2, 1'b0, 1'b0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
